// File: rtl/apb_regfile_slave_pkg.sv
// apb_regfile_slave_pkg: default APB4 request/response structs for the register-file completer
package apb_regfile_slave_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } req_t;
    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } resp_t;
endpackage

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB4 completer holding byte-strobed control/status registers with wait states
module apb_regfile_slave
    import apb_regfile_slave_pkg::*;
#(
    parameter int NoRegs = 8,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr = '0,
    parameter int WaitCycles = 2,
    parameter logic [NoRegs-1:0] ReadOnly = '0,
    parameter logic [NoRegs-1:0][DataWidth-1:0] RegRstVal = '0,
    parameter type apb_req_t = req_t,
    parameter type apb_resp_t = resp_t
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  apb_req_t                          apb_req_i,
    output apb_resp_t                         apb_resp_o,
    output logic [NoRegs-1:0][DataWidth-1:0]  reg_q_o,
    input  logic [NoRegs-1:0]                 reg_load_i,
    input  logic [NoRegs-1:0][DataWidth-1:0]  reg_load_data_i
);
    localparam int Nb = DataWidth / 8;
    localparam int Iw = NoRegs > 1 ? $clog2(NoRegs) : 1;
    typedef enum logic {IDLE, WAIT} state_e;
    state_e state;
    logic [3:0] cnt;
    logic [AddrWidth-1:0] off, idx;
    logic [Iw-1:0] sel;
    logic mapped, err, rdy, wr_en;
    logic unused_pprot;
    assign unused_pprot = ^apb_req_i.pprot;
    always_comb begin
        off = apb_req_i.paddr - BaseAddr;
        idx = off >> $clog2(Nb);
        mapped = apb_req_i.paddr >= BaseAddr && idx < AddrWidth'(NoRegs);
        sel = mapped ? idx[Iw-1:0] : '0;
        err = !mapped || (apb_req_i.pwrite && ReadOnly[sel]);
        rdy = state == WAIT && apb_req_i.psel && apb_req_i.penable && cnt == '0;
        wr_en = rdy && apb_req_i.pwrite && !err;
        apb_resp_o = '0;
        apb_resp_o.pready = rdy;
        apb_resp_o.pslverr = rdy && err;
        apb_resp_o.prdata = rdy && !apb_req_i.pwrite && mapped ? reg_q_o[sel] : '0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
        end else if (state == IDLE) begin
            if (apb_req_i.psel && !apb_req_i.penable) begin
                state <= WAIT;
                cnt <= 4'(WaitCycles);
            end
        end else if (!apb_req_i.psel || rdy) begin
            state <= IDLE;
        end else if (apb_req_i.penable) begin
            cnt <= cnt - 4'd1;
        end
    end
    // APB write wins on strobed bytes, hardware load keeps the rest
    always_ff @(posedge clk_i) begin
        if (rst_i) reg_q_o <= RegRstVal;
        else
            for (int k = 0; k < NoRegs; k++)
                for (int b = 0; b < Nb; b++)
                    if (wr_en && sel == Iw'(k) && apb_req_i.pstrb[b])
                        reg_q_o[k][8*b +: 8] <= apb_req_i.pwdata[8*b +: 8];
                    else if (reg_load_i[k])
                        reg_q_o[k][8*b +: 8] <= reg_load_data_i[k][8*b +: 8];
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: three completers (0/2/5 wait states) on one bus against a register model
module tb_apb_regfile_slave;
    import apb_regfile_slave_pkg::*;
    localparam logic [31:0] BASE = 32'h100;
    localparam logic [7:0] RO = 8'h20;
    localparam logic [7:0][31:0] RST = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hA5A5_0000, 32'h0, 32'h0, 32'h0};
    localparam int WC [3] = '{0, 2, 5};
    logic clk = 0;
    logic rst = 1;
    req_t req;
    resp_t rsp [3];
    logic [7:0][31:0] q [3];
    logic [7:0] ld_en [3];
    logic [7:0][31:0] ld_dat [3];
    logic [7:0][31:0] mdl [3];
    int total = 0;
    int bad = 0;
    bit rnd_ld = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_regfile_slave #(
            .NoRegs(8), .AddrWidth(32), .DataWidth(32), .BaseAddr(BASE),
            .WaitCycles(g == 0 ? 0 : g == 1 ? 2 : 5), .ReadOnly(RO), .RegRstVal(RST)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .apb_req_i(req), .apb_resp_o(rsp[g]),
            .reg_q_o(q[g]), .reg_load_i(ld_en[g]), .reg_load_data_i(ld_dat[g])
        );
    end
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic set_ld(input int c, input bit ldc, input logic [31:0] ldv);
        logic [31:0] off;
        off = req.paddr - BASE;
        for (int i = 0; i < 3; i++) begin
            ld_en[i] = '0;
            for (int k = 0; k < 8; k++) begin
                ld_dat[i][k] = $urandom;
                if (rnd_ld && $urandom_range(0, 7) == 0) ld_en[i][k] = 1'b1;
            end
            if (ldc && c > 0 && c == WC[i] + 1 && req.paddr >= BASE && off < 32) begin
                ld_en[i][int'(off[4:2])] = 1'b1;
                ld_dat[i][int'(off[4:2])] = ldv;
            end
        end
    endtask
    task automatic tick(input int c);
        logic [31:0] off;
        int idx;
        bit mapped, err, rdy;
        #1;
        off = req.paddr - BASE;
        mapped = req.paddr >= BASE && off < 32;
        idx = int'(off[4:2]);
        err = !mapped || (req.pwrite && RO[idx]);
        for (int i = 0; i < 3; i++) begin
            rdy = c > 0 && c == WC[i] + 1;
            chk($sformatf("pready%0d", i), rsp[i].pready, rdy);
            chk($sformatf("pslverr%0d", i), rsp[i].pslverr, rdy && err);
            chk($sformatf("prdata%0d", i), rsp[i].prdata, (rdy && !req.pwrite && mapped) ? mdl[i][idx] : 32'h0);
            chk($sformatf("regs%0d", i), q[i], mdl[i]);
            chk($sformatf("apb_rules%0d", i), (rsp[i].pready & ~(req.psel & req.penable)) | (rsp[i].pslverr & ~rsp[i].pready), 0);
            for (int k = 0; k < 8; k++)
                if (ld_en[i][k]) mdl[i][k] = ld_dat[i][k];
            if (rdy && req.pwrite && !err)
                for (int b = 0; b < 4; b++)
                    if (req.pstrb[b]) mdl[i][idx][8*b +: 8] = req.pwdata[8*b +: 8];
        end
        @(posedge clk);
    endtask
    task automatic idle();
        @(negedge clk);
        req.psel = 0;
        req.penable = 0;
        set_ld(0, 0, 0);
        tick(0);
    endtask
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int len, input bit ldc, input logic [31:0] ldv);
        @(negedge clk);
        req.psel = 1;
        req.penable = 0;
        req.pwrite = wr;
        req.paddr = a;
        req.pwdata = d;
        req.pstrb = s;
        req.pprot = 3'($urandom);
        set_ld(0, 0, 0);
        tick(0);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            req.penable = 1;
            set_ld(c, ldc, ldv);
            tick(c);
        end
        if (len < 6) idle();
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        req = '0;
        for (int i = 0; i < 3; i++) ld_en[i] = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) mdl[i] = RST;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_q3_%0d", i), q[i][3], 32'hA5A5_0000);
            chk($sformatf("rst_resp%0d", i), rsp[i], 0);
        end
    endtask
    initial begin
        req = '0;
        for (int i = 0; i < 3; i++) begin
            ld_en[i] = '0;
            ld_dat[i] = '0;
        end
        repeat (3) @(posedge clk);
        do_reset();
        xfer(1, BASE + 8, 32'h1234_5678, 4'b0101, 6, 0, 0);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("strb_wr%0d", i), q[i][2], 32'h0034_0078);
        xfer(0, BASE + 32, 0, 0, 6, 0, 0);
        xfer(0, BASE - 4, 0, 0, 6, 0, 0);
        xfer(1, BASE + 20, 32'h0, 4'hF, 6, 0, 0);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("ro_wr%0d", i), q[i][5], 32'hDEAD_BEEF);
        xfer(1, BASE + 4, 32'h0, 4'b0011, 6, 1, 32'hFFFF_FFFF);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("ld_vs_wr%0d", i), q[i][1], 32'hFFFF_0000);
        xfer(1, BASE + 12, 32'hFFFF_FFFF, 4'h0, 6, 0, 0);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("strb0_%0d", i), q[i][3], 32'hA5A5_0000);
        xfer(0, BASE + 14, 0, 0, 6, 0, 0);
        xfer(1, BASE, 32'hCAFE_F00D, 4'hF, 1, 0, 0);
        #1;
        chk("abort_w0", q[0][0], 32'hCAFE_F00D);
        chk("abort_w2", q[1][0], 32'h0);
        chk("abort_w5", q[2][0], 32'h0);
        @(negedge clk);
        req.psel = 1;
        req.penable = 0;
        req.pwrite = 1;
        req.paddr = BASE + 16;
        req.pwdata = 32'h1111_1111;
        req.pstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req.penable = 1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        req.psel = 0;
        req.penable = 0;
        for (int i = 0; i < 3; i++) mdl[i] = RST;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstwait_rdy%0d", i), rsp[i].pready, 0);
            chk($sformatf("rstwait_q4_%0d", i), q[i][4], 32'h0);
            chk($sformatf("rstwait_q0_%0d", i), q[i][0], 32'h0);
        end
        rnd_ld = 1;
        repeat (300) begin
            logic [31:0] a;
            a = $urandom_range(0, 15) == 0 ? BASE - 4 * $urandom_range(1, 4)
                                           : BASE + 4 * $urandom_range(0, 9) + $urandom_range(0, 3);
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 5)) : 6,
                 $urandom_range(0, 3) == 0, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        rnd_ld = 0;
        for (int k = 0; k < 8; k++) xfer(0, BASE + 4 * k, 0, 0, 6, 0, 0);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
